pc_ctrl: RTL and testbench

- Parametrised program-counter and next-PC controller for the pipelined core; the next generation of the fetch-stage PC.
- Tracks one in-flight conditional branch or register jump over a configurable resolve latency, and resolves it from execute-stage operands.
- Adds over the previous PC: stall freeze, selectable signed compare, sign-correct branch offsets, a flush pulse, and restart after halt.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_ctrl_br_cond.sv | 53 +++++
 rtl/pc_ctrl.sv | 115 +++++++++++
 tb/tb_pc_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared opcodes, FSM state encoding and counter sizing for the fetch-stage PC controller.
package pc_pkg;

  localparam int unsigned OP_BEQ  = 32;
  localparam int unsigned OP_BNE  = 33;
  localparam int unsigned OP_BLT  = 34;
  localparam int unsigned OP_BLE  = 35;
  localparam int unsigned OP_JR   = 42;
  localparam int unsigned OP_HALT = 63;

  // Wide enough for the largest legal resolve latency (7).
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_ctrl_br_cond.sv
// Branch condition evaluator: decides whether the resolving branch/JR is taken and where it lands.
module br_cond
  import pc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int OP_W       = 6,
  parameter int ADDR_SHIFT = 2,
  parameter int SIGNED_CMP = 1
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] os,
  input  logic [XLEN-1:0] ot,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] nextSeq;
  logic [XLEN-1:0] wordOffset;
  logic [XLEN-1:0] branchTarget;
  logic            isEq;
  logic            isLtSigned;
  logic            isLtUnsigned;
  logic            isLt;

  // Offsets are byte offsets; the arithmetic shift keeps backward branches negative.
  assign nextSeq      = ex_pc + XLEN'(1);
  assign wordOffset   = $signed(imm) >>> ADDR_SHIFT;
  assign branchTarget = nextSeq + wordOffset;

  assign isEq         = (os == ot);
  assign isLtSigned   = ($signed(os) < $signed(ot));
  assign isLtUnsigned = (os < ot);
  assign isLt         = (SIGNED_CMP != 0) ? isLtSigned : isLtUnsigned;

  always_comb begin
    taken  = 1'b0;
    target = nextSeq;
    case (op)
      OP_W'(OP_BEQ): taken = isEq;
      OP_W'(OP_BNE): taken = !isEq;
      OP_W'(OP_BLT): taken = isLt;
      OP_W'(OP_BLE): taken = isLt || isEq;
      OP_W'(OP_JR):  taken = 1'b1;
      default:       taken = 1'b0;
    endcase
    if (taken) begin
      target = (op == OP_W'(OP_JR)) ? os : branchTarget;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage program counter with one pending branch/JR resolved after BR_LAT cycles,
// stall freeze, halt/resume and a registered flush pulse on taken redirects.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int JADDR_W    = 26,
  parameter int OP_W       = 6,
  parameter int ADDR_SHIFT = 2,
  parameter int BR_LAT     = 2,
  parameter int SIGNED_CMP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jmp_valid,
  input  logic [JADDR_W-1:0] jmp_addr,
  input  logic               br_dec,
  input  logic [OP_W-1:0]    ex_op,
  input  logic [XLEN-1:0]    ex_os,
  input  logic [XLEN-1:0]    ex_ot,
  input  logic [XLEN-1:0]    ex_imm,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic               resume,
  output logic [XLEN-1:0]    pc,
  output logic               flush,
  output logic               halted
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BR_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             flush_q, flush_d;

  logic             resolveNow;
  logic             brTaken;
  logic [XLEN-1:0]  brTarget;
  logic [XLEN-1:0]  jmpTarget;
  logic [XLEN-1:0]  pcPlusOne;

  br_cond #(
    .XLEN      (XLEN),
    .OP_W      (OP_W),
    .ADDR_SHIFT(ADDR_SHIFT),
    .SIGNED_CMP(SIGNED_CMP)
  ) u_br_cond (
    .op    (ex_op),
    .os    (ex_os),
    .ot    (ex_ot),
    .ex_pc (ex_pc),
    .imm   (ex_imm),
    .taken (brTaken),
    .target(brTarget)
  );

  assign resolveNow = (state_q == WAIT) && (cnt_q == CNT_ONE);
  assign jmpTarget  = XLEN'(jmp_addr) >> ADDR_SHIFT;
  assign pcPlusOne  = pc_q + XLEN'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    flush_d = 1'b0;

    if (state_q == HALT) begin
      if (resume) begin
        pc_d    = pcPlusOne;
        state_d = RUN;
      end
    end else if (!stall) begin
      if (resolveNow) begin
        // Resolve beats any same-cycle jump: that jump is younger and sits in a shadow slot.
        pc_d    = brTarget;
        flush_d = brTaken;
        state_d = RUN;
        cnt_d   = '0;
      end else if (ex_op == OP_W'(OP_HALT)) begin
        pc_d    = ex_pc;
        state_d = HALT;
        cnt_d   = '0;
      end else begin
        pc_d = jmp_valid ? jmpTarget : pcPlusOne;
        if (state_q == WAIT) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (br_dec) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  assign pc     = pc_q;
  assign flush  = flush_q;
  assign halted = (state_q == HALT);

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: a signed-compare and an unsigned-compare instance share stimulus;
// table rows feed a scoreboard queue, hand-written sequences cover asynchronous reset mid-WAIT/HALT.
module tb_pc_ctrl;

  localparam logic [5:0] BEQ  = 6'd32;
  localparam logic [5:0] BNE  = 6'd33;
  localparam logic [5:0] BLT  = 6'd34;
  localparam logic [5:0] BLE  = 6'd35;
  localparam logic [5:0] JR   = 6'd42;
  localparam logic [5:0] HLT  = 6'd63;

  typedef struct {
    logic        stall;
    logic        jmpValid;
    logic [25:0] jmpAddr;
    logic        brDec;
    logic [5:0]  op;
    logic [31:0] os;
    logic [31:0] ot;
    logic [31:0] imm;
    logic [31:0] exPc;
    logic        resume;
    logic [31:0] expPc;
    logic [31:0] expPcU;
    logic        expFlush;
    logic        expFlushU;
    logic        expHalted;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, jmpValid, brDec, resume;
  logic [25:0] jmpAddr;
  logic [5:0]  exOp;
  logic [31:0] exOs, exOt, exImm, exPc;
  logic [31:0] pc, pcU;
  logic        flush, flushU, halted, haltedU;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  vec_t sbQueue[$];

  always #5 clk = ~clk;

  pc_ctrl #(.SIGNED_CMP(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jmp_valid(jmpValid), .jmp_addr(jmpAddr),
    .br_dec(brDec), .ex_op(exOp), .ex_os(exOs), .ex_ot(exOt), .ex_imm(exImm),
    .ex_pc(exPc), .resume(resume), .pc(pc), .flush(flush), .halted(halted)
  );

  pc_ctrl #(.SIGNED_CMP(0)) dutU (
    .clk(clk), .rst(rst), .stall(stall), .jmp_valid(jmpValid), .jmp_addr(jmpAddr),
    .br_dec(brDec), .ex_op(exOp), .ex_os(exOs), .ex_ot(exOt), .ex_imm(exImm),
    .ex_pc(exPc), .resume(resume), .pc(pcU), .flush(flushU), .halted(haltedU)
  );

  function automatic vec_t mk(input logic st, input logic jv, input logic [25:0] ja,
                              input logic bd, input logic [5:0] op,
                              input logic [31:0] os, input logic [31:0] ot,
                              input logic [31:0] imm, input logic [31:0] xpc, input logic res,
                              input logic [31:0] ePc, input logic [31:0] ePcU,
                              input logic eFl, input logic eFlU, input logic eH);
    vec_t v;
    v.stall = st; v.jmpValid = jv; v.jmpAddr = ja; v.brDec = bd; v.op = op;
    v.os = os; v.ot = ot; v.imm = imm; v.exPc = xpc; v.resume = res;
    v.expPc = ePc; v.expPcU = ePcU; v.expFlush = eFl; v.expFlushU = eFlU; v.expHalted = eH;
    return v;
  endfunction

  // Expected values are what pc/flush/halted show right after the edge that consumes the row.
  task automatic fillTable();
    //            st jv ja        bd op    os            ot     imm           exPc   res  pc            pcU           fl flU h
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h1,        32'h1,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h2,        32'h2,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h3,        32'h3,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h4,        32'h4,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h5,        32'h5,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h6,        32'h6,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, BEQ,  32'h7,        32'h7, 32'h8,        32'h5,  0, 32'h8,        32'h8,        1, 1, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h9,        32'h9,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'hA,        32'hA,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'hB,        32'hB,        0, 0, 0));
    vecs.push_back(mk(0, 1, 26'h100, 0, BNE,  32'h7,        32'h7, 32'h8,        32'hA,  0, 32'hB,        32'hB,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'hC,        32'hC,        0, 0, 0));
    vecs.push_back(mk(0, 1, 26'h40,  0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h10,       32'h10,       0, 0, 0));
    vecs.push_back(mk(1, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h10,       32'h10,       0, 0, 0));
    vecs.push_back(mk(1, 1, 26'h80,  0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h10,       32'h10,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h11,       32'h11,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h12,       32'h12,       0, 0, 0));
    vecs.push_back(mk(1, 0, 26'h0,   0, BEQ,  32'h3,        32'h3, 32'h0,        32'h0,  0, 32'h12,       32'h12,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h13,       32'h13,       0, 0, 0));
    vecs.push_back(mk(1, 0, 26'h0,   0, JR,   32'h55,       32'h0, 32'h0,        32'h0,  0, 32'h13,       32'h13,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, BEQ,  32'h1,        32'h2, 32'h40,       32'h30, 0, 32'h31,       32'h31,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h32,       32'h32,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h33,       32'h33,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, BLT,  32'hFFFFFFFF, 32'h1, 32'hFFFFFFF8, 32'hA,  0, 32'h9,        32'hB,        1, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'hA,        32'hC,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'hB,        32'hD,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'hC,        32'hE,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, BLE,  32'h5,        32'h5, 32'h10,       32'h20, 0, 32'h25,       32'h25,       1, 1, 0));
    vecs.push_back(mk(0, 0, 26'h0,   1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h26,       32'h26,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h27,       32'h27,       0, 0, 0));
    vecs.push_back(mk(0, 1, 26'h80,  0, JR,   32'h20,       32'h0, 32'h0,        32'h0,  0, 32'h20,       32'h20,       1, 1, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h21,       32'h21,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h22,       32'h22,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h23,       32'h23,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, JR,   32'hFFFFFFFF, 32'h0, 32'h0,        32'h0,  0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h1,        32'h1,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h2,        32'h2,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd5, 32'h0,        32'h0, 32'h0,        32'h40, 0, 32'h41,       32'h41,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, HLT,  32'h0,        32'h0, 32'h0,        32'h9,  0, 32'h9,        32'h9,        0, 0, 1));
    vecs.push_back(mk(0, 1, 26'h80,  1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h9,        32'h9,        0, 0, 1));
    vecs.push_back(mk(1, 1, 26'h80,  0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h9,        32'h9,        0, 0, 1));
    vecs.push_back(mk(0, 1, 26'h80,  0, HLT,  32'h0,        32'h0, 32'h0,        32'h70, 0, 32'h9,        32'h9,        0, 0, 1));
    vecs.push_back(mk(0, 1, 26'h80,  0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h9,        32'h9,        0, 0, 1));
    vecs.push_back(mk(0, 1, 26'h80,  1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'h9,        32'h9,        0, 0, 1));
    vecs.push_back(mk(1, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  1, 32'hA,        32'hA,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'hB,        32'hB,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   1, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  0, 32'hC,        32'hC,        0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, HLT,  32'h0,        32'h0, 32'h0,        32'h50, 0, 32'h50,       32'h50,       0, 0, 1));
    vecs.push_back(mk(0, 0, 26'h0,   0, 6'd0, 32'h0,        32'h0, 32'h0,        32'h0,  1, 32'h51,       32'h51,       0, 0, 0));
    vecs.push_back(mk(0, 0, 26'h0,   0, BEQ,  32'h1,        32'h1, 32'h100,      32'h60, 0, 32'h52,       32'h52,       0, 0, 0));
  endtask

  task automatic driveIdle();
    stall = 1'b0; jmpValid = 1'b0; jmpAddr = '0; brDec = 1'b0; exOp = '0;
    exOs = '0; exOt = '0; exImm = '0; exPc = '0; resume = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    stall = v.stall; jmpValid = v.jmpValid; jmpAddr = v.jmpAddr; brDec = v.brDec;
    exOp = v.op; exOs = v.os; exOt = v.ot; exImm = v.imm; exPc = v.exPc; resume = v.resume;
    sbQueue.push_back(v);
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL row%0d scoreboard: got empty queue, expected an entry", idx);
    end else begin
      e = sbQueue.pop_front();
      checkValue($sformatf("row%0d pc", idx), pc, e.expPc);
      checkValue($sformatf("row%0d flush", idx), {31'b0, flush}, {31'b0, e.expFlush});
      checkValue($sformatf("row%0d halted", idx), {31'b0, halted}, {31'b0, e.expHalted});
      checkValue($sformatf("row%0d pcU", idx), pcU, e.expPcU);
      checkValue($sformatf("row%0d flushU", idx), {31'b0, flushU}, {31'b0, e.expFlushU});
      checkValue($sformatf("row%0d haltedU", idx), {31'b0, haltedU}, {31'b0, e.expHalted});
    end
  endtask

  task automatic stepAndCheckPc(input string name, input logic [31:0] expPc, input logic expFlush,
                                input logic expHalted);
    @(posedge clk);
    #1;
    checkValue({name, " pc"}, pc, expPc);
    checkValue({name, " flush"}, {31'b0, flush}, {31'b0, expFlush});
    checkValue({name, " halted"}, {31'b0, halted}, {31'b0, expHalted});
    checkValue({name, " pcU"}, pcU, expPc);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    driveIdle();
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset pc", pc, 32'h0);
    checkValue("reset flush", {31'b0, flush}, 32'h0);
    checkValue("reset halted", {31'b0, halted}, 32'h0);
    checkValue("reset pcU", pcU, 32'h0);
    rst = 1'b0;

    fillTable();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(i);
    end

    // Reset while the pending branch is in its last cycle before resolve.
    driveIdle();
    brDec = 1'b1;
    stepAndCheckPc("seqA br", 32'h53, 1'b0, 1'b0);
    driveIdle();
    stepAndCheckPc("seqA wait", 32'h54, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkValue("seqA async pc", pc, 32'h0);
    checkValue("seqA async pcU", pcU, 32'h0);
    stepAndCheckPc("seqA held", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    exOp = JR; exOs = 32'h77;
    stepAndCheckPc("seqA noredir", 32'h1, 1'b0, 1'b0);
    driveIdle();
    stepAndCheckPc("seqA next", 32'h2, 1'b0, 1'b0);

    // Reset while halted must return to normal fetch.
    exOp = HLT; exPc = 32'h30;
    stepAndCheckPc("seqB halt", 32'h30, 1'b0, 1'b1);
    driveIdle();
    #2;
    rst = 1'b1;
    #1;
    checkValue("seqB async pc", pc, 32'h0);
    checkValue("seqB async halted", {31'b0, halted}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stepAndCheckPc("seqB run", 32'h1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
